// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp colour codes and FSM state encoding shared by the light controllers
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_WALK   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin finder: first set request after base, wrapping
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Walk from the farthest offset down so the nearest request after base wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N; k >= 1; k--) begin
      pos = IDX_W'((int'(base) + k) % N);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - multi-approach intersection scheduler with demand counting,
// round-robin green grants, yellow/all-red clearance and a pedestrian walk phase
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int CNT_W     = 3,
  parameter int THRESH    = 5,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_APPR-1:0]           car_sense,
  input  logic                        ped_req,
  output logic [2*N_APPR-1:0]         light,
  output logic [$clog2(N_APPR)-1:0]   active_idx,
  output logic                        ped_walk,
  output logic                        phase_done
);

  localparam int IDX_W = $clog2(N_APPR);
  localparam int TMR_W = $clog2(GREEN_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(GREEN_MAX);
  localparam logic [TMR_W-1:0] GMIN_END = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] GMAX_END = TMR_W'(GREEN_MAX - 1);
  localparam logic [TMR_W-1:0] YEL_END  = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] AR_END   = TMR_W'(ALLRED_T - 1);
  localparam logic [TMR_W-1:0] WALK_END = TMR_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  nxt_q, nxt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              ped_pend_q, ped_pend_d;
  logic              phase_done_q, phase_done_d;
  logic [CNT_W-1:0]  cnt_q [N_APPR];
  logic [CNT_W-1:0]  cnt_d [N_APPR];

  logic [N_APPR-1:0] qual;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              enter_green;
  logic              green_exit;

  always_comb begin
    qual = '0;
    for (int i = 0; i < N_APPR; i++) begin
      qual[i] = (cnt_q[i] >= CNT_THR) && (cur_q != IDX_W'(i));
    end
  end

  rr_pick #(
    .N     (N_APPR),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (qual),
    .base  (cur_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign green_exit = ((tmr_q >= GMIN_END) && ((|qual) || ped_pend_q)) ||
                      ((cur_q != '0) && (tmr_q == GMAX_END));

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    enter_green = 1'b0;
    tmr_d       = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;

    case (state_q)
      S_GREEN: begin
        if (green_exit) begin
          state_d = S_YELLOW;
          nxt_d   = pick_valid ? pick_idx : '0;
        end
      end
      S_YELLOW: begin
        if (tmr_q == YEL_END) begin
          state_d = S_ALLRED;
        end
      end
      S_ALLRED: begin
        if (tmr_q == AR_END) begin
          if (ped_pend_q) begin
            state_d = S_WALK;
          end else begin
            enter_green = 1'b1;
          end
        end
      end
      S_WALK: begin
        if (tmr_q == WALK_END) begin
          enter_green = 1'b1;
        end
      end
      default: state_d = S_GREEN;
    endcase

    if (enter_green) begin
      state_d = S_GREEN;
      cur_d   = nxt_q;
    end

    // Every transition is a change of state, so this is exactly "clear on entry".
    if (state_d != state_q) begin
      tmr_d = '0;
    end

    ped_pend_d = ped_pend_q | (ped_req && (state_q != S_WALK));
    if ((state_d == S_WALK) && (state_q != S_WALK)) begin
      ped_pend_d = 1'b0;
    end

    phase_done_d = enter_green;

    // The granted approach's count is zeroed on the entry edge and pinned there while green.
    for (int i = 0; i < N_APPR; i++) begin
      cnt_d[i] = cnt_q[i];
      if (car_sense[i] && (cnt_q[i] != CNT_SAT)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (((state_q == S_GREEN) && (cur_q == IDX_W'(i))) ||
          (enter_green && (nxt_q == IDX_W'(i)))) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_GREEN;
      cur_q        <= '0;
      nxt_q        <= '0;
      tmr_q        <= '0;
      ped_pend_q   <= 1'b0;
      phase_done_q <= 1'b0;
      for (int i = 0; i < N_APPR; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      tmr_q        <= tmr_d;
      ped_pend_q   <= ped_pend_d;
      phase_done_q <= phase_done_d;
      for (int i = 0; i < N_APPR; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    light = '0;
    for (int i = 0; i < N_APPR; i++) begin
      light[2*i +: 2] = RED;
      if (cur_q == IDX_W'(i)) begin
        if (state_q == S_GREEN) begin
          light[2*i +: 2] = GREEN;
        end else if (state_q == S_YELLOW) begin
          light[2*i +: 2] = YELLOW;
        end
      end
    end
  end

  assign active_idx = cur_q;
  assign ped_walk   = (state_q == S_WALK);
  assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] car_sense;
  logic       ped_req;
  logic [7:0] light;
  logic [1:0] active_idx;
  logic       ped_walk;
  logic       phase_done;

  int checks = 0;
  int errors = 0;

  traffic_phase_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .car_sense  (car_sense),
    .ped_req    (ped_req),
    .light      (light),
    .active_idx (active_idx),
    .ped_walk   (ped_walk),
    .phase_done (phase_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] car, input logic ped);
    car_sense = car;
    ped_req   = ped;
    @(posedge clock);
    #1;
    car_sense = '0;
    ped_req   = 1'b0;
  endtask

  task automatic wait_phase(input string tag);
    int n;
    n = 0;
    do begin
      cyc(4'b0000, 1'b0);
      n++;
    end while (!phase_done && n < 40);
    check(tag, phase_done, 1'b1);
  endtask

  initial begin
    int n;
    int pd;
    reset     = 1'b1;
    car_sense = '0;
    ped_req   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_light", light, 8'b00000010);
    check("rst_idx", active_idx, 2'd0);
    check("rst_done", phase_done, 1'b0);
    reset = 1'b0;

    // Idle: home road rests green.
    pd = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(4'b0000, 1'b0);
      pd += int'(phase_done);
    end
    check("idle_light", light, 8'b00000010);
    check("idle_idx", active_idx, 2'd0);
    check("idle_done_cnt", pd, 0);

    // Five cars on approach 2.
    for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b0);
    check("a2_cnt5", dut.cnt_q[2], 3'd5);
    check("a2_still_green", light, 8'b00000010);
    cyc(4'b0000, 1'b0);
    check("a0_yellow1", light, 8'b00000001);
    cyc(4'b0000, 1'b0);
    check("a0_yellow2", light, 8'b00000001);
    cyc(4'b0000, 1'b0);
    check("allred", light, 8'b00000000);
    cyc(4'b0000, 1'b0);
    check("a2_green", light, 8'b00100000);
    check("a2_done", phase_done, 1'b1);
    check("a2_idx", active_idx, 2'd2);
    check("a2_cnt_clr", dut.cnt_q[2], 3'd0);

    // No other demand: approach 2 runs to GREEN_MAX.
    n = 0;
    while (light == 8'b00100000 && n < 30) begin
      n++;
      cyc(4'b0000, 1'b0);
    end
    check("a2_green_len", n, 10);
    check("a2_yellow", light, 8'b00010000);
    wait_phase("home_ret");
    check("home_ret_light", light, 8'b00000010);
    check("home_ret_idx", active_idx, 2'd0);

    // Round robin from 2 with 1 and 3 qualified: 3, 1, 0.
    for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b0);
    wait_phase("rr_a2");
    check("rr_a2_idx", active_idx, 2'd2);
    for (int i = 0; i < 5; i++) cyc(4'b1010, 1'b0);
    check("rr_cnt3", dut.cnt_q[3], 3'd5);
    check("rr_a2_hold", light, 8'b00100000);
    wait_phase("rr_a3");
    check("rr_a3_light", light, 8'b10000000);
    check("rr_a3_idx", active_idx, 2'd3);
    n = 0;
    while (light == 8'b10000000 && n < 30) begin
      n++;
      cyc(4'b0000, 1'b0);
    end
    check("rr_a3_len_min", n, 4);
    wait_phase("rr_a1");
    check("rr_a1_light", light, 8'b00001000);
    check("rr_a1_idx", active_idx, 2'd1);
    n = 0;
    while (light == 8'b00001000 && n < 30) begin
      n++;
      cyc(4'b0000, 1'b0);
    end
    check("rr_a1_len_max", n, 10);
    wait_phase("rr_a0");
    check("rr_a0_light", light, 8'b00000010);

    // Pedestrian request at home tmr=1.
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b1);
    check("ped_green_t2", light, 8'b00000010);
    cyc(4'b0000, 1'b0);
    check("ped_green_t3", light, 8'b00000010);
    cyc(4'b0000, 1'b0);
    check("ped_yellow", light, 8'b00000001);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    check("ped_allred", light, 8'b00000000);
    check("ped_allred_walk", ped_walk, 1'b0);
    cyc(4'b0000, 1'b0);
    check("ped_walk_on", ped_walk, 1'b1);
    check("ped_walk_light", light, 8'b00000000);
    n = 0;
    while (ped_walk && n < 20) begin
      n++;
      cyc(4'b0000, n == 1);
    end
    check("walk_len", n, 6);
    check("walk_home", light, 8'b00000010);
    check("walk_done", phase_done, 1'b1);
    check("walk_pend_ign", dut.ped_pend_q, 1'b0);

    // Reset during yellow of approach 3.
    for (int i = 0; i < 5; i++) cyc(4'b1000, 1'b0);
    wait_phase("a3_grant");
    check("a3_light", light, 8'b10000000);
    cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b0);
    n = 0;
    while (light != 8'b01000000 && n < 30) begin
      n++;
      cyc(4'b0000, 1'b0);
    end
    check("a3_yellow", light, 8'b01000000);
    check("a3_cnt1", dut.cnt_q[1], 3'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_light", light, 8'b00000010);
    check("mid_rst_idx", active_idx, 2'd0);
    check("mid_rst_cnt1", dut.cnt_q[1], 3'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Saturation, then clear-on-grant beating a same-cycle increment.
    for (int i = 0; i < 8; i++) cyc(4'b0100, 1'b0);
    check("sat_cnt", dut.cnt_q[2], 3'd7);
    check("sat_allred", light, 8'b00000000);
    cyc(4'b0100, 1'b0);
    check("sat_clr", dut.cnt_q[2], 3'd0);
    check("sat_grant", light, 8'b00100000);
    check("sat_done", phase_done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
